mux_2_1_arbiter: RTL and testbench
==================================

MUX_2_1_ARBITER -- requirements
Module: mux_2_1_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the per-requester data width.
REQ-002 Parameter MAX_BURST, default 16, SHALL set the maximum beats per locked grant; legal range 2..256.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  input  2  SHALL carry the per-requester valid; bit i belongs to requester i.
REQ-006 in_ready  output  2  SHALL carry the per-requester ready.
REQ-007 in_last  input  2  SHALL mark the final beat of requester i's burst.
REQ-008 data_in  input  2*WIDTH  SHALL carry the requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  SHALL be the registered output valid.
REQ-010 out_ready  input  1  SHALL be the downstream ready.
REQ-011 data_out  output  WIDTH  SHALL carry the registered data of the selected requester.
REQ-012 out_last  output  1  SHALL carry the registered in_last of the accepted beat.
REQ-013 out_src  output  1  SHALL identify which requester produced the current output beat.

Function
REQ-014 Transfer on input i SHALL occur when in_valid[i] && in_ready[i]; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Output stage SHALL be a one-entry register; in_ready[i] = (grant==i) && (!out_valid || out_ready); latency input accept to out_valid SHALL be exactly 1 cycle.
REQ-016 At most one in_ready bit SHALL be high in any cycle.
REQ-017 When unlocked, grant SHALL be computed combinationally: only one valid -> that one; both valid -> requester != last_winner; none -> no grant.
REQ-018 last_winner SHALL update to the accepted requester on every input transfer.
REQ-019 State machine: UNLOCKED, LOCKED; UNLOCKED -> LOCKED on an accepted beat with in_last=0; LOCKED -> UNLOCKED on an accepted beat with in_last=1 or when beat_cnt reaches MAX_BURST.
REQ-020 In LOCKED, grant SHALL stay on the owner regardless of the other requester's valid; an owner valid low SHALL stall, not release.
REQ-021 beat_cnt SHALL count accepted beats of the current grant, starting at 1 on the first beat, and clear on release; forced release at MAX_BURST SHALL re-enter arbitration the next cycle with the other requester favoured.
REQ-022 Output stall (out_valid=1, out_ready=0) SHALL hold data_out, out_last and out_src stable and block all input transfers.
REQ-023 Simultaneous output drain and input accept in one cycle SHALL replace the register without a bubble.
REQ-024 data_out SHALL be exactly the WIDTH-bit slice of the granted requester; no width conversion.

Reset
REQ-025 On reset_n low: out_valid=0, data_out=0, out_last=0, out_src=0, in_ready=0, state=UNLOCKED, beat_cnt=0, last_winner=1 (requester 0 wins first tie).
REQ-026 Reset asserted mid-burst SHALL discard the held beat and lock; no beat SHALL be emitted after deassertion without a new input transfer.

Configuration
REQ-027 Macro MUX_ARB_BURST_LOCK_EN defined: REQ-019..021 lock behaviour SHALL apply.
REQ-028 Macro MUX_ARB_BURST_LOCK_EN undefined: state SHALL remain UNLOCKED, every beat arbitrated per REQ-017, in_last only forwarded to out_last, MAX_BURST unused.

Verification
REQ-029 Reset release, both valid, single-beat (last=1), out_ready=1, data 0xA0/0xB1 -> outputs alternate 0xA0(src0), 0xB1(src1), ... one per cycle.
REQ-030 Lock enabled, req0 4-beat burst 0x01..0x04 (last on 4th), req1 valid throughout -> four src0 beats back-to-back, then req1 granted.
REQ-031 Lock enabled, MAX_BURST=4, req0 streams 10 beats with last=0, req1 valid -> src0 x4, src1 next, req0 resumes after.
REQ-032 out_ready held low 3 cycles with out_valid=1 data 0x55 -> data_out=0x55 stable, in_ready=2'b00 all 3 cycles.
REQ-033 reset_n pulsed low mid-burst after beat 2 of 4 -> out_valid=0 next cycle, state UNLOCKED, req1 wins first tie only if last_winner rule gives it (req0 wins).
REQ-034 Lock disabled, req0 burst with last=0 and req1 valid -> grants alternate every beat.

Source files
------------

// File: rtl/mux_2_1_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage.
// Define MUX_ARB_BURST_LOCK_EN to hold a grant across a burst until in_last or MAX_BURST beats.
module mux_2_1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         in_valid,
  output logic [1:0]         in_ready,
  input  logic [1:0]         in_last,
  input  logic [2*WIDTH-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_last,
  output logic               out_src
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef MUX_ARB_BURST_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next, beat_inc;
  logic             last_winner, last_winner_next;
  logic             grant_valid, grant_idx;
  logic             out_free, accept, accept_last;
  logic [WIDTH-1:0] lane [2];

  // While locked the owner is last_winner, since it was updated on the locking beat.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (state == LOCKED) begin
      grant_valid = 1'b1;
      grant_idx   = last_winner;
    end else begin
      case (in_valid)
        2'b01:   begin grant_valid = 1'b1; grant_idx = 1'b0;         end
        2'b10:   begin grant_valid = 1'b1; grant_idx = 1'b1;         end
        2'b11:   begin grant_valid = 1'b1; grant_idx = ~last_winner; end
        default: begin grant_valid = 1'b0; grant_idx = 1'b0;         end
      endcase
    end
  end

  assign out_free = !out_valid || out_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane[gi]     = data_in[gi*WIDTH +: WIDTH];
    assign in_ready[gi] = reset_n && out_free && grant_valid && (grant_idx == 1'(gi));
  end

  assign accept      = |(in_valid & in_ready);
  assign accept_last = in_last[grant_idx];
  assign beat_inc    = beat_cnt + CNT_W'(1);

  always_comb begin
    state_next       = state;
    beat_cnt_next    = beat_cnt;
    last_winner_next = last_winner;
    if (accept) begin
      last_winner_next = grant_idx;
      // beat_inc is 1 on an unlocked beat, so MAX_BURST >= 2 never releases it early.
      if (!LOCK_EN || accept_last || (beat_inc == CNT_W'(MAX_BURST))) begin
        state_next    = UNLOCKED;
        beat_cnt_next = '0;
      end else begin
        state_next    = LOCKED;
        beat_cnt_next = beat_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= UNLOCKED;
      beat_cnt    <= '0;
      last_winner <= 1'b1;
    end else begin
      state       <= state_next;
      beat_cnt    <= beat_cnt_next;
      last_winner <= last_winner_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_out  <= lane[grant_idx];
      out_last  <= accept_last;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Directed bench for mux_2_1_arbiter; lock-specific expectations follow MUX_ARB_BURST_LOCK_EN.
module tb_mux_2_1_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  in_last;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        out_last;
  logic        out_src;

  int n_checks = 0;
  int n_pass   = 0;

  mux_2_1_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (reset_n) check("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);

  initial begin
    reset_n   = 1'b0;
    in_valid  = 2'b11;
    in_last   = 2'b11;
    data_in   = {8'hB1, 8'hA0};
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out",  32'(data_out),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);

    // Single-beat tie: alternate starting with requester 0.
    reset_n = 1'b1;
    #1;
    check("alt_first_ready", 32'(in_ready), 32'b01);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("alt_valid", 32'(out_valid), 32'd1);
      check("alt_src",   32'(out_src),   32'(k % 2));
      check("alt_data",  32'(data_out),  (k % 2) ? 32'hB1 : 32'hA0);
      check("alt_ready", 32'(in_ready),  (k % 2) ? 32'b01 : 32'b10);
    end

    // Output stall holds the register and blocks inputs, then refills without a bubble.
    in_valid = 2'b01;
    data_in  = {8'h00, 8'h55};
    tick();
    check("stall_load", 32'(data_out), 32'h55);
    out_ready = 1'b0;
    in_valid  = 2'b11;
    data_in   = {8'h77, 8'h66};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_data",  32'(data_out),  32'h55);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_src",   32'(out_src),   32'd0);
      check("stall_ready", 32'(in_ready),  32'b00);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(in_ready), 32'b10);
    tick();
    check("refill_data",  32'(data_out),  32'h77);
    check("refill_src",   32'(out_src),   32'd1);
    check("refill_valid", 32'(out_valid), 32'd1);
    in_valid = 2'b00;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // req0 streams last=0 beats against a single-beat req1.
    in_valid = 2'b11;
    in_last  = 2'b10;
    data_in  = {8'h20, 8'h10};
    for (int k = 0; k < 10; k++) begin
      automatic int exp_src;
`ifdef MUX_ARB_BURST_LOCK_EN
      exp_src = ((k % 5) < 4) ? 0 : 1;
`else
      exp_src = k % 2;
`endif
      tick();
      check("stream_src",  32'(out_src),  32'(exp_src));
      check("stream_data", 32'(data_out), exp_src ? 32'h20 : 32'h10);
      check("stream_last", 32'(out_last), 32'(exp_src));
    end
    in_valid = 2'b00;
    tick();

`ifdef MUX_ARB_BURST_LOCK_EN
    // Four-beat req0 burst holds the grant, then req1 gets its turn.
    in_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      data_in = {8'h20, 8'(j + 1)};
      in_last = {1'b1, (j == 3)};
      tick();
      check("burst_src",  32'(out_src),  32'd0);
      check("burst_data", 32'(data_out), 32'(j + 1));
      check("burst_last", 32'(out_last), 32'(j == 3));
    end
    tick();
    check("after_burst_src",  32'(out_src),  32'd1);
    check("after_burst_data", 32'(data_out), 32'h20);
    in_valid = 2'b00;
    tick();
`endif

    // Reset in the middle of a burst drops the held beat and the lock.
    in_valid = 2'b01;
    in_last  = 2'b00;
    data_in  = {8'h30, 8'h01};
    tick();
    check("mid_beat1", 32'(data_out), 32'h01);
    data_in = {8'h30, 8'h02};
    tick();
    check("mid_beat2", 32'(data_out), 32'h02);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(data_out),  32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'b00);
    tick();
    reset_n  = 1'b1;
    in_valid = 2'b00;
    tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    in_valid = 2'b11;
    in_last  = 2'b11;
    data_in  = {8'h30, 8'h03};
    #1;
    check("post_rst_tie", 32'(in_ready), 32'b01);
    tick();
    check("post_rst_src",  32'(out_src),  32'd0);
    check("post_rst_data", 32'(data_out), 32'h03);
    check("post_rst_last", 32'(out_last), 32'd1);
    in_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
